// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencer for the five-stage core.
//
// Generates the stall and flush controls for PC, IF/ID, ID/EX and EX/MEM from
//   * load-use hazards (ID opcode decoded to find which sources are really read),
//   * control redirects resolved in EX (taken branch, JAL, JALR),
//   * multi-cycle data-memory waits.
// Two saturating performance counters track stall cycles and redirect flushes.
//
// Ports
//   clk          in   core clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   id_opcode    in   [6:0] opcode of the instruction in ID
//   id_rs1       in   [4:0] rs1 field of the instruction in ID
//   id_rs2       in   [4:0] rs2 field of the instruction in ID
//   ex_rd        in   [4:0] destination register of the instruction in EX
//   ex_mem_read  in   instruction in EX is a load
//   ex_redirect  in   EX resolved a taken branch / JAL / JALR this cycle
//   mem_busy     in   data memory not ready, MEM stage must hold
//   pc_stall     out  hold PC
//   ifid_stall   out  hold IF/ID
//   ifid_flush   out  zero IF/ID (NOP)
//   idex_stall   out  hold ID/EX
//   idex_flush   out  zero ID/EX control (bubble)
//   exmem_stall  out  hold EX/MEM
//   stall_cnt    out  [CNT_W-1:0] cycles with pc_stall=1, saturating
//   flush_cnt    out  [CNT_W-1:0] honoured redirects, saturating
module hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0]       BUB_INIT = 3'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       bub_cnt_q, bub_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic uses_rs1, uses_rs2, load_use;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c;
  logic idex_stall_c, idex_flush_c, exmem_stall_c;
  logic flush_inc_c;

  // Decode which source registers the ID-stage instruction actually reads.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
      end
      default: begin
        // LUI, AUIPC, JAL and unknown opcodes read no register.
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // x0 never carries a real dependency, so a load to x0 cannot cause a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (ex_rd == id_rs1)) ||
                     (uses_rs2 && (ex_rd == id_rs2)));

  // Sequencer: control outputs and next state; priority mem_busy > redirect > load-use.
  always_comb begin
    state_d       = state_q;
    bub_cnt_d     = bub_cnt_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_stall_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_stall_c = 1'b0;
    flush_inc_c   = 1'b0;

    case (state_q)
      // MEM_WAIT with memory ready behaves exactly like RUN in the same cycle.
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
          state_d       = ST_MEM_WAIT;
        end else if (ex_redirect) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          flush_inc_c  = 1'b1;
          state_d      = ST_RUN;
        end else if (load_use) begin
          // The ID/EX register takes a bubble rather than holding the consumer.
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
          if (LU_BUBBLES == 1) begin
            state_d = ST_RUN;
          end else begin
            bub_cnt_d = BUB_INIT;
            state_d   = ST_LU_STALL;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_LU_STALL: begin
        if (mem_busy) begin
          // Freeze without consuming a bubble.
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          idex_stall_c  = 1'b1;
          exmem_stall_c = 1'b1;
        end else if (ex_redirect) begin
          // The stalled consumer is on the wrong path; drop the remaining bubbles.
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          flush_inc_c  = 1'b1;
          bub_cnt_d    = 3'd0;
          state_d      = ST_RUN;
        end else begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
          bub_cnt_d    = bub_cnt_q - 3'd1;
          if (bub_cnt_q == 3'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LU_STALL;
          end
        end
      end

      default: begin
        state_d   = ST_RUN;
        bub_cnt_d = 3'd0;
      end
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    if (pc_stall_c && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_inc_c && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, bubble counter and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      bub_cnt_q   <= 3'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      bub_cnt_q   <= bub_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are combinational from inputs, so force them low while reset is held.
  assign pc_stall    = pc_stall_c    & rst_n;
  assign ifid_stall  = ifid_stall_c  & rst_n;
  assign ifid_flush  = ifid_flush_c  & rst_n;
  assign idex_stall  = idex_stall_c  & rst_n;
  assign idex_flush  = idex_flush_c  & rst_n;
  assign exmem_stall = exmem_stall_c & rst_n;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Three instances share one set
// of inputs: u_b1 (LU_BUBBLES=1, CNT_W=4), u_b3 (LU_BUBBLES=3), u_b2 (LU_BUBBLES=2).
// Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, ex_redirect, mem_busy;

  logic [5:0]  ctl1, ctl2, ctl3;
  logic [3:0]  scnt1, fcnt1;
  logic [15:0] scnt2, fcnt2, scnt3, fcnt3;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_LU     = 6'b110010;
  localparam logic [5:0] C_FLUSH  = 6'b001010;
  localparam logic [5:0] C_FREEZE = 6'b110101;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(4)) u_b1 (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_stall(ctl1[5]), .ifid_stall(ctl1[4]), .ifid_flush(ctl1[3]), .idex_stall(ctl1[2]),
    .idex_flush(ctl1[1]), .exmem_stall(ctl1[0]), .stall_cnt(scnt1), .flush_cnt(fcnt1));

  hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(16)) u_b2 (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_stall(ctl2[5]), .ifid_stall(ctl2[4]), .ifid_flush(ctl2[3]), .idex_stall(ctl2[2]),
    .idex_flush(ctl2[1]), .exmem_stall(ctl2[0]), .stall_cnt(scnt2), .flush_cnt(fcnt2));

  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(16)) u_b3 (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_stall(ctl3[5]), .ifid_stall(ctl3[4]), .ifid_flush(ctl3[3]), .idex_stall(ctl3[2]),
    .idex_flush(ctl3[1]), .exmem_stall(ctl3[0]), .stall_cnt(scnt3), .flush_cnt(fcnt3));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic redir, input logic busy);
    id_opcode   = op;
    id_rs1      = rs1;
    id_rs2      = rs2;
    ex_rd       = rd;
    ex_mem_read = mr;
    ex_redirect = redir;
    mem_busy    = busy;
  endtask

  task automatic idle();
    drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Reset state, with a hazard present on the inputs: controls must stay low.
    drive(7'b0010011, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rst_ctl", {10'd0, ctl1}, {10'd0, C_NONE});
    chk("rst_scnt", {12'd0, scnt1}, 16'd0);
    chk("rst_fcnt", {12'd0, fcnt1}, 16'd0);
    do_reset();

    // T1: I-type load-use on rs1, single bubble.
    drive(7'b0010011, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t1_lu", {10'd0, ctl1}, {10'd0, C_LU});
    tick();
    idle();
    settle();
    chk("t1_after", {10'd0, ctl1}, {10'd0, C_NONE});
    chk("t1_scnt", {12'd0, scnt1}, 16'd1);

    // T2: no hazard through x0, LUI, or I-type rs2 field; hazard for JALR rs1 and R rs2.
    do_reset();
    drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t2_x0", {10'd0, ctl1}, {10'd0, C_NONE});
    tick();
    drive(7'b0110111, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t2_lui", {10'd0, ctl1}, {10'd0, C_NONE});
    tick();
    drive(7'b0010011, 5'd4, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t2_i_rs2", {10'd0, ctl1}, {10'd0, C_NONE});
    tick();
    drive(7'b1100111, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t2_jalr", {10'd0, ctl1}, {10'd0, C_LU});
    tick();
    drive(7'b0110011, 5'd1, 5'd12, 5'd12, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t2_r_rs2", {10'd0, ctl1}, {10'd0, C_LU});
    tick();
    idle();
    settle();
    chk("t2_scnt", {12'd0, scnt1}, 16'd2);

    // T3: S-type rs2 hazard with three bubbles.
    do_reset();
    drive(7'b0100011, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t3_b1", {10'd0, ctl3}, {10'd0, C_LU});
    tick();
    idle();
    settle();
    chk("t3_b2", {10'd0, ctl3}, {10'd0, C_LU});
    tick();
    settle();
    chk("t3_b3", {10'd0, ctl3}, {10'd0, C_LU});
    tick();
    settle();
    chk("t3_run", {10'd0, ctl3}, {10'd0, C_NONE});
    chk("t3_scnt", scnt3, 16'd3);

    // T4: redirect beats load-use.
    do_reset();
    drive(7'b0010011, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    settle();
    chk("t4_flush", {10'd0, ctl1}, {10'd0, C_FLUSH});
    tick();
    idle();
    settle();
    chk("t4_scnt", {12'd0, scnt1}, 16'd0);
    chk("t4_fcnt", {12'd0, fcnt1}, 16'd1);

    // Redirect during LU_STALL aborts the remaining bubbles.
    do_reset();
    drive(7'b0010011, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("lu_abort_flush", {10'd0, ctl3}, {10'd0, C_FLUSH});
    tick();
    idle();
    settle();
    chk("lu_abort_run", {10'd0, ctl3}, {10'd0, C_NONE});
    chk("lu_abort_fcnt", fcnt3, 16'd1);

    // mem_busy beats redirect; leaving MEM_WAIT applies RUN rules at once.
    do_reset();
    drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("mw_freeze", {10'd0, ctl1}, {10'd0, C_FREEZE});
    tick();
    settle();
    chk("mw_hold", {10'd0, ctl1}, {10'd0, C_FREEZE});
    tick();
    drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("mw_exit_flush", {10'd0, ctl1}, {10'd0, C_FLUSH});
    tick();
    idle();
    settle();
    chk("mw_scnt", {12'd0, scnt1}, 16'd2);
    chk("mw_fcnt", {12'd0, fcnt1}, 16'd1);

    // T5: LU_BUBBLES=2, mem_busy for 3 cycles during LU_STALL.
    do_reset();
    drive(7'b0000011, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t5_lu", {10'd0, ctl2}, {10'd0, C_LU});
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      settle();
      chk("t5_freeze", {10'd0, ctl2}, {10'd0, C_FREEZE});
    end
    tick();
    idle();
    settle();
    chk("t5_bubble", {10'd0, ctl2}, {10'd0, C_LU});
    tick();
    settle();
    chk("t5_run", {10'd0, ctl2}, {10'd0, C_NONE});
    chk("t5_scnt", scnt2, 16'd5);

    // T6: asynchronous reset in the middle of LU_STALL.
    do_reset();
    drive(7'b0010011, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    chk("t6_pre", {10'd0, ctl2}, {10'd0, C_LU});
    mem_busy = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ctl", {10'd0, ctl2}, {10'd0, C_NONE});
    chk("t6_async_scnt", scnt2, 16'd0);
    tick();
    idle();
    rst_n = 1'b1;
    settle();
    chk("t6_state_run", {10'd0, ctl2}, {10'd0, C_NONE});

    // Saturation with CNT_W=4: 20 stall cycles and 20 redirects.
    do_reset();
    drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_scnt", {12'd0, scnt1}, 16'd15);
    drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    idle();
    settle();
    chk("sat_fcnt", {12'd0, fcnt1}, 16'd15);
    chk("sat_scnt_hold", {12'd0, scnt1}, 16'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
